// File: rtl/ps2_pkg.sv
// Shared types for the PS/2 scan decoder: frame states, prefix defaults, key event.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_e;

  localparam logic [7:0] EXT_CODE_DEF = 8'hE0;
  localparam logic [7:0] BRK_CODE_DEF = 8'hF0;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_evt_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame deserialiser: start, 8 data LSB-first, odd parity, stop.
// PS2_PARITY_CHECK_EN makes a parity error reject the frame; otherwise only the stop bit counts.
import ps2_pkg::*;

module ps2_frame_rx (
  input  logic       ps2_nclk,
  input  logic       nReset,
  input  logic       ndata_i,
  output logic [7:0] byte_o,
  output logic       good_o,
  output logic       bad_o,
  output logic       busy_o
);

`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_CHK = 1'b1;
`else
  localparam bit PAR_CHK = 1'b0;
`endif

  frame_state_e state_q, state_d;
  logic [2:0]   bitcnt_q, bitcnt_d;
  logic [7:0]   shift_q, shift_d;
  logic         par_q, par_d;
  logic         par_ok;

  always_ff @(negedge ps2_nclk or negedge nReset) begin
    if (!nReset) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
    end
  end

  assign par_ok = ^{shift_q, par_q};

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    good_o   = 1'b0;
    bad_o    = 1'b0;
    case (state_q)
      IDLE: begin
        // A high line while idle is not a start bit; wait for the next edge.
        if (!ndata_i) begin
          state_d  = DATA;
          bitcnt_d = '0;
        end
      end
      DATA: begin
        shift_d[bitcnt_q] = ndata_i;
        bitcnt_d          = bitcnt_q + 3'd1;
        if (bitcnt_q == 3'd7) state_d = PARITY;
      end
      PARITY: begin
        par_d   = ndata_i;
        state_d = STOP;
      end
      STOP: begin
        good_o  = ndata_i & (par_ok | ~PAR_CHK);
        bad_o   = ~good_o;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign byte_o = shift_q;
  assign busy_o = (state_q != IDLE);

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 keyboard front end: folds E0/F0 prefixes into one {ext, brk, code} event with a CDC toggle.
// PS2_PARITY_CHECK_EN enables parity rejection in the frame receiver.
import ps2_pkg::*;

module ps2_scan_decoder #(
  parameter int         ERR_W    = 4,
  parameter logic [7:0] EXT_CODE = EXT_CODE_DEF,
  parameter logic [7:0] BRK_CODE = BRK_CODE_DEF
) (
  input  logic             ps2_nclk,
  input  logic             nReset,
  input  logic             ndata,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_brk,
  output logic             key_toggle,
  output logic [7:0]       raw_byte,
  output logic             frame_err,
  output logic [ERR_W-1:0] err_count,
  output logic             busy
);

  logic [7:0]       rx_byte;
  logic             rx_good, rx_bad;
  key_evt_t         key_q;
  logic             tog_q, ext_pend_q, brk_pend_q, ferr_q;
  logic [7:0]       raw_q;
  logic [ERR_W-1:0] err_q;

  ps2_frame_rx u_rx (
    .ps2_nclk (ps2_nclk),
    .nReset   (nReset),
    .ndata_i  (ndata),
    .byte_o   (rx_byte),
    .good_o   (rx_good),
    .bad_o    (rx_bad),
    .busy_o   (busy)
  );

  always_ff @(negedge ps2_nclk or negedge nReset) begin
    if (!nReset) begin
      key_q      <= '0;
      tog_q      <= 1'b0;
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
      ferr_q     <= 1'b0;
      raw_q      <= '0;
      err_q      <= '0;
    end else if (rx_good) begin
      raw_q  <= rx_byte;
      ferr_q <= 1'b0;
      if (rx_byte == EXT_CODE) begin
        ext_pend_q <= 1'b1;
      end else if (rx_byte == BRK_CODE) begin
        brk_pend_q <= 1'b1;
      end else begin
        key_q      <= '{ext: ext_pend_q, brk: brk_pend_q, code: rx_byte};
        tog_q      <= ~tog_q;
        ext_pend_q <= 1'b0;
        brk_pend_q <= 1'b0;
      end
    end else if (rx_bad) begin
      // A bad frame may have been a lost key byte, so stale prefixes are dropped.
      ferr_q     <= 1'b1;
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
      if (err_q != '1) err_q <= err_q + 1'b1;
    end
  end

  assign key_code   = key_q.code;
  assign key_ext    = key_q.ext;
  assign key_brk    = key_q.brk;
  assign key_toggle = tog_q;
  assign raw_byte   = raw_q;
  assign frame_err  = ferr_q;
  assign err_count  = err_q;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Bench for ps2_scan_decoder: directed frame table, corner sequences, random frames vs. a frame-level model.
module tb_ps2_scan_decoder;

`ifdef PS2_PARITY_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  logic       ps2_nclk = 1'b1;
  logic       nReset   = 1'b0;
  logic       ndata    = 1'b1;
  logic [7:0] key_code, raw_byte;
  logic       key_ext, key_brk, key_toggle, frame_err, busy;
  logic [3:0] err_count;

  int n_chk  = 0;
  int n_fail = 0;

  ps2_scan_decoder #(.ERR_W(4), .EXT_CODE(8'hE0), .BRK_CODE(8'hF0)) dut (
    .ps2_nclk   (ps2_nclk),
    .nReset     (nReset),
    .ndata      (ndata),
    .key_code   (key_code),
    .key_ext    (key_ext),
    .key_brk    (key_brk),
    .key_toggle (key_toggle),
    .raw_byte   (raw_byte),
    .frame_err  (frame_err),
    .err_count  (err_count),
    .busy       (busy)
  );

  always #10 ps2_nclk = ~ps2_nclk;

  typedef struct {
    logic [7:0] d;
    logic       par;
    logic       stp;
    logic [7:0] code;
    logic       ext, brk, tog;
    logic [7:0] raw;
    logic       err;
    logic [3:0] cnt;
  } vec_t;

  vec_t tbl[12];

  // frame-level reference model state
  logic [7:0] m_code, m_raw;
  logic       m_ext, m_brk, m_tog, m_err, m_ep, m_bp;
  logic [3:0] m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction

  function automatic vec_t mk(input logic [7:0] d, input logic par, input logic stp,
                              input logic [7:0] code, input logic ext, input logic brk,
                              input logic tog, input logic [7:0] raw, input logic err,
                              input logic [3:0] cnt);
    vec_t v;
    v.d = d; v.par = par; v.stp = stp; v.code = code; v.ext = ext; v.brk = brk;
    v.tog = tog; v.raw = raw; v.err = err; v.cnt = cnt;
    return v;
  endfunction

  task automatic send_bit(input logic b);
    @(posedge ps2_nclk);
    ndata = b;
    @(negedge ps2_nclk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
    send_bit(1'b0);
    chk("busy_in_frame", busy, 1'b1);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stp);
  endtask

  task automatic chk_out(input string tag, input logic [7:0] code, input logic ext,
                         input logic brk, input logic tog, input logic [7:0] raw,
                         input logic err, input logic [3:0] cnt);
    chk({tag, ".code"}, key_code, code);
    chk({tag, ".ext"}, key_ext, ext);
    chk({tag, ".brk"}, key_brk, brk);
    chk({tag, ".tog"}, key_toggle, tog);
    chk({tag, ".raw"}, raw_byte, raw);
    chk({tag, ".err"}, frame_err, err);
    chk({tag, ".cnt"}, err_count, cnt);
    chk({tag, ".busy"}, busy, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge ps2_nclk);
    nReset = 1'b0;
    ndata  = 1'b1;
    repeat (2) @(negedge ps2_nclk);
    #1;
    nReset = 1'b1;
    m_code = '0; m_raw = '0; m_ext = 0; m_brk = 0; m_tog = 0; m_err = 0;
    m_ep = 0; m_bp = 0; m_cnt = '0;
  endtask

  task automatic model_frame(input logic [7:0] d, input logic par, input logic stp);
    logic ok;
    ok = stp && (!PCHK || (^{d, par}));
    if (!ok) begin
      m_err = 1'b1;
      m_ep  = 1'b0;
      m_bp  = 1'b0;
      if (m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
    end else begin
      m_raw = d;
      m_err = 1'b0;
      if (d == 8'hE0)      m_ep = 1'b1;
      else if (d == 8'hF0) m_bp = 1'b1;
      else begin
        m_code = d; m_ext = m_ep; m_brk = m_bp; m_tog = ~m_tog;
        m_ep = 1'b0; m_bp = 1'b0;
      end
    end
  endtask

  initial begin
    logic [7:0] c8, d;
    logic       t8, p, s;
    logic [3:0] n8;

    // reset state
    nReset = 1'b0;
    repeat (2) @(negedge ps2_nclk);
    #1;
    chk_out("reset", 8'h00, 0, 0, 0, 8'h00, 0, 4'h0);
    nReset = 1'b1;
    m_code = '0; m_raw = '0; m_ext = 0; m_brk = 0; m_tog = 0; m_err = 0;
    m_ep = 0; m_bp = 0; m_cnt = '0;

    // directed table: 1C; F0 1C; E0 F0 75; 29; parity error; stop error; F0 + bad + 12
    c8 = PCHK ? 8'h29 : 8'h1C;
    t8 = PCHK ? 1'b0  : 1'b1;
    n8 = PCHK ? 4'd1  : 4'd0;
    tbl[0]  = mk(8'h1C, 0, 1, 8'h1C, 0, 0, 1, 8'h1C, 0, 4'd0);
    tbl[1]  = mk(8'hF0, 1, 1, 8'h1C, 0, 0, 1, 8'hF0, 0, 4'd0);
    tbl[2]  = mk(8'h1C, 0, 1, 8'h1C, 0, 1, 0, 8'h1C, 0, 4'd0);
    tbl[3]  = mk(8'hE0, 0, 1, 8'h1C, 0, 1, 0, 8'hE0, 0, 4'd0);
    tbl[4]  = mk(8'hF0, 1, 1, 8'h1C, 0, 1, 0, 8'hF0, 0, 4'd0);
    tbl[5]  = mk(8'h75, 0, 1, 8'h75, 1, 1, 1, 8'h75, 0, 4'd0);
    tbl[6]  = mk(8'h29, 0, 1, 8'h29, 0, 0, 0, 8'h29, 0, 4'd0);
    tbl[7]  = mk(8'h1C, 1, 1, c8, 0, 0, t8, c8, PCHK, n8);
    tbl[8]  = mk(8'h5A, 1, 0, c8, 0, 0, t8, c8, 1, n8 + 4'd1);
    tbl[9]  = mk(8'hF0, 1, 1, c8, 0, 0, t8, 8'hF0, 0, n8 + 4'd1);
    tbl[10] = mk(8'h12, 1, 0, c8, 0, 0, t8, 8'hF0, 1, n8 + 4'd2);
    tbl[11] = mk(8'h12, 1, 1, 8'h12, 0, 0, ~t8, 8'h12, 0, n8 + 4'd2);
    for (int i = 0; i < 12; i++) begin
      send_frame(tbl[i].d, tbl[i].par, tbl[i].stp);
      chk_out($sformatf("tbl%0d", i), tbl[i].code, tbl[i].ext, tbl[i].brk, tbl[i].tog,
              tbl[i].raw, tbl[i].err, tbl[i].cnt);
    end

    // error counter saturation
    do_reset();
    for (int i = 0; i < 17; i++) send_frame(8'h33, 1'b1, 1'b0);
    chk("sat.cnt", err_count, 4'hF);
    chk("sat.err", frame_err, 1'b1);
    chk("sat.tog", key_toggle, 1'b0);

    // idle high line is ignored, then a normal frame
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send_bit(1'b1);
      chk("idle.busy", busy, 1'b0);
    end
    send_frame(8'h29, 1'b0, 1'b1);
    chk_out("idle29", 8'h29, 0, 0, 1, 8'h29, 0, 4'd0);

    // reset mid-frame after a prefix and 5 bits
    send_frame(8'hE0, 1'b0, 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    chk("mid.busy", busy, 1'b1);
    #2 nReset = 1'b0;
    #2 chk_out("midrst", 8'h00, 0, 0, 0, 8'h00, 0, 4'd0);
    nReset = 1'b1;
    send_frame(8'h5A, 1'b1, 1'b1);
    chk_out("post5A", 8'h5A, 0, 0, 1, 8'h5A, 0, 4'd0);

    // random frames against the model
    do_reset();
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 7))
        0, 1:    d = 8'hE0;
        2, 3:    d = 8'hF0;
        4:       d = 8'hE1;
        default: d = 8'($urandom);
      endcase
      p = odd_par(d) ^ ($urandom_range(0, 7) == 0);
      s = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) send_bit(1'b1);
      send_frame(d, p, s);
      model_frame(d, p, s);
      chk_out("rand", m_code, m_ext, m_brk, m_tog, m_raw, m_err, m_cnt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
